bev_core: RTL and testbench



---
 rtl/Usertype_BEV.sv | 72 +++++++
 rtl/INF.sv | 26 ++
 rtl/bev_recipe.sv | 53 +++++
 rtl/bev_core.sv | 209 ++++++++++++++++++++
 tb/tb_bev_core.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/Usertype_BEV.sv
// Shared types for the beverage-shop controller: actions, recipes, sizes,
// error codes, the 64-bit ingredient box and the 72-bit input data bus.
package Usertype_BEV;

   typedef enum logic [1:0] {
      Make_drink       = 2'd0,
      Supply           = 2'd1,
      Check_Valid_Date = 2'd2
   } Action;

   typedef enum logic [2:0] {
      Black_Tea                = 3'd0,
      Milk_Tea                 = 3'd1,
      Extra_Milk_Tea           = 3'd2,
      Green_Tea                = 3'd3,
      Green_Milk_Tea           = 3'd4,
      Pineapple_Juice          = 3'd5,
      Super_Pineapple_Tea      = 3'd6,
      Super_Pineapple_Milk_Tea = 3'd7
   } Bev_Type;

   typedef enum logic [1:0] {
      L = 2'b00,
      M = 2'b01,
      S = 2'b11
   } Bev_Size;

   typedef enum logic [1:0] {
      No_Err = 2'd0,
      No_Exp = 2'd1,
      No_Ing = 2'd2,
      Ing_OF = 2'd3
   } Error_Msg;

   typedef logic [11:0] Ing;
   typedef logic [3:0]  Month;
   typedef logic [4:0]  Day;
   typedef logic [7:0]  Barrel_No;

   // Drink volumes in the same units as the stored ingredient amounts
   localparam Ing VOL_L = 12'd960;
   localparam Ing VOL_M = 12'd720;
   localparam Ing VOL_S = 12'd480;

   typedef struct packed {
      Ing         bt;
      Ing         gt;
      logic [3:0] mon_pad;
      Month       mon;
      Ing         mk;
      Ing         pj;
      logic [2:0] day_pad;
      Day         day;
   } Bev_Bal;

   // One view of the input bus per kind of valid strobe
   typedef union packed {
      logic [71:0] raw;
      struct packed { logic [69:0] pad; Action    act;  } d_act;
      struct packed { logic [68:0] pad; Bev_Type  typ;  } d_type;
      struct packed { logic [69:0] pad; Bev_Size  size; } d_size;
      struct packed { logic [62:0] pad; Month mon; Day day; } d_date;
      struct packed { logic [63:0] pad; Barrel_No no;   } d_box_no;
      struct packed { logic [59:0] pad; Ing       ing;  } d_ing;
   } Data;

   // Clamp a 13-bit ingredient sum to the 12-bit storage range
   function automatic Ing ing_sat(input logic [12:0] s);
      return s[12] ? 12'hFFF : s[11:0];
   endfunction

endpackage

// File: rtl/INF.sv
// Shared pattern/bridge interface of the beverage controller.
interface INF;
   logic        rst_n;
   logic        sel_action_valid;
   logic        type_valid;
   logic        size_valid;
   logic        date_valid;
   logic        box_no_valid;
   logic        box_sup_valid;
   logic [71:0] D;
   logic        out_valid;
   logic [1:0]  err_msg;
   logic        complete;
   logic [7:0]  C_addr;
   logic        C_r_wb;
   logic        C_in_valid;
   logic [63:0] C_data_w;
   logic [63:0] C_data_r;
   logic        C_out_valid;

   modport BEV_inf (
      input  rst_n, sel_action_valid, type_valid, size_valid, date_valid,
             box_no_valid, box_sup_valid, D, C_data_r, C_out_valid,
      output out_valid, err_msg, complete, C_addr, C_r_wb, C_in_valid, C_data_w
   );
endinterface

// File: rtl/bev_recipe.sv
// Combinational recipe table: (type, size) -> ingredient needs per drink.
module bev_recipe
   import Usertype_BEV::*;
(
   input  Bev_Type i_type,
   input  Bev_Size i_size,
   output Ing      o_bt,
   output Ing      o_gt,
   output Ing      o_mk,
   output Ing      o_pj
);

   Ing w_vol;
   Ing w_half;
   Ing w_qtr;
   Ing w_3qtr;

   // Volume by size; the unused size code yields a zero-volume drink
   always_comb begin
      w_vol = '0;
      case (i_size)
         L:       w_vol = VOL_L;
         M:       w_vol = VOL_M;
         S:       w_vol = VOL_S;
         default: w_vol = '0;
      endcase
   end

   // All volumes are multiples of 4, so the ratio splits are exact shifts
   assign w_half = w_vol >> 1;
   assign w_qtr  = w_vol >> 2;
   assign w_3qtr = w_vol - w_qtr;

   // Split the volume across ingredients according to the recipe ratio
   always_comb begin
      o_bt = '0;
      o_gt = '0;
      o_mk = '0;
      o_pj = '0;
      case (i_type)
         Black_Tea:                o_bt = w_vol;
         Milk_Tea:                 begin o_bt = w_3qtr; o_mk = w_qtr;  end
         Extra_Milk_Tea:           begin o_bt = w_half; o_mk = w_half; end
         Green_Tea:                o_gt = w_vol;
         Green_Milk_Tea:           begin o_gt = w_half; o_mk = w_half; end
         Pineapple_Juice:          o_pj = w_vol;
         Super_Pineapple_Tea:      begin o_bt = w_half; o_pj = w_half; end
         Super_Pineapple_Milk_Tea: begin o_bt = w_half; o_mk = w_qtr; o_pj = w_qtr; end
         default:                  o_bt = '0;
      endcase
   end

endmodule

// File: rtl/bev_core.sv
// Beverage-shop controller: collects one action, reads the box through the
// bridge, computes the result, optionally writes the box back, reports.
module bev_core
   import Usertype_BEV::*;
(
   input logic   clk,
   INF.BEV_inf   inf
);

   typedef enum logic [2:0] {
      IDLE, GET_INPUT, READ_REQ, READ_WAIT, CALC, WRITE_REQ, WRITE_WAIT, OUT
   } state_t;

   state_t          r_state;
   Action           r_act;
   Bev_Type         r_type;
   Bev_Size         r_size;
   Month            r_mon;
   Day              r_day;
   Barrel_No        r_box_no;
   logic [3:0][11:0] r_sup;
   logic [1:0]      r_sup_cnt;
   Bev_Bal          r_box;
   Error_Msg        r_res_err;

   logic            r_out_valid;
   Error_Msg        r_err;
   logic            r_complete;
   Barrel_No        r_c_addr;
   logic            r_c_r_wb;
   logic            r_c_in_valid;
   Bev_Bal          r_c_data_w;

   Data             w_d;
   logic            w_unused;
   Ing              w_need_bt, w_need_gt, w_need_mk, w_need_pj;
   logic            w_expired;
   logic            w_short;
   logic [12:0]     w_s_bt, w_s_gt, w_s_mk, w_s_pj;
   logic            w_of;
   Bev_Bal          w_new;
   Error_Msg        w_err;
   logic            w_wr;

   assign w_d      = inf.D;
   assign w_unused = |w_d.raw[71:12];

   bev_recipe u_recipe (
      .i_type (r_type),
      .i_size (r_size),
      .o_bt   (w_need_bt),
      .o_gt   (w_need_gt),
      .o_mk   (w_need_mk),
      .o_pj   (w_need_pj)
   );

   // Today later than the box date means expired; equal dates are fine
   assign w_expired = (r_mon > r_box.mon) ||
                      ((r_mon == r_box.mon) && (r_day > r_box.day));
   assign w_short   = (r_box.bt < w_need_bt) || (r_box.gt < w_need_gt) ||
                      (r_box.mk < w_need_mk) || (r_box.pj < w_need_pj);

   assign w_s_bt = {1'b0, r_box.bt} + {1'b0, r_sup[0]};
   assign w_s_gt = {1'b0, r_box.gt} + {1'b0, r_sup[1]};
   assign w_s_mk = {1'b0, r_box.mk} + {1'b0, r_sup[2]};
   assign w_s_pj = {1'b0, r_box.pj} + {1'b0, r_sup[3]};
   assign w_of   = w_s_bt[12] | w_s_gt[12] | w_s_mk[12] | w_s_pj[12];

   // Result of the action on the fetched box: error code, new box, write flag
   always_comb begin
      w_new = r_box;
      w_err = No_Err;
      w_wr  = 1'b0;
      case (r_act)
         Make_drink: begin
            if (w_expired)    w_err = No_Exp;
            else if (w_short) w_err = No_Ing;
            else begin
               w_new.bt = r_box.bt - w_need_bt;
               w_new.gt = r_box.gt - w_need_gt;
               w_new.mk = r_box.mk - w_need_mk;
               w_new.pj = r_box.pj - w_need_pj;
               w_wr     = 1'b1;
            end
         end
         Supply: begin
            w_new.bt      = ing_sat(w_s_bt);
            w_new.gt      = ing_sat(w_s_gt);
            w_new.mk      = ing_sat(w_s_mk);
            w_new.pj      = ing_sat(w_s_pj);
            w_new.mon_pad = '0;
            w_new.mon     = r_mon;
            w_new.day_pad = '0;
            w_new.day     = r_day;
            w_wr          = 1'b1;
            if (w_of) w_err = Ing_OF;
         end
         default: begin
            if (w_expired) w_err = No_Exp;
         end
      endcase
   end

   // Control FSM with registered bridge and result outputs
   always_ff @(posedge clk) begin
      if (!inf.rst_n) begin
         r_state      <= IDLE;
         r_act        <= Make_drink;
         r_type       <= Black_Tea;
         r_size       <= L;
         r_mon        <= '0;
         r_day        <= '0;
         r_box_no     <= '0;
         r_sup        <= '0;
         r_sup_cnt    <= '0;
         r_box        <= '0;
         r_res_err    <= No_Err;
         r_out_valid  <= 1'b0;
         r_err        <= No_Err;
         r_complete   <= 1'b0;
         r_c_addr     <= '0;
         r_c_r_wb     <= 1'b0;
         r_c_in_valid <= 1'b0;
         r_c_data_w   <= '0;
      end else begin
         r_c_in_valid <= 1'b0;
         r_out_valid  <= 1'b0;
         r_err        <= No_Err;
         r_complete   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (inf.sel_action_valid) begin
                  r_act     <= w_d.d_act.act;
                  r_sup_cnt <= '0;
                  r_state   <= GET_INPUT;
               end
            end
            GET_INPUT: begin
               if (inf.type_valid) r_type <= w_d.d_type.typ;
               if (inf.size_valid) r_size <= w_d.d_size.size;
               if (inf.date_valid) begin
                  r_mon <= w_d.d_date.mon;
                  r_day <= w_d.d_date.day;
               end
               if (inf.box_no_valid) begin
                  r_box_no <= w_d.d_box_no.no;
                  if (r_act != Supply) begin
                     r_c_in_valid <= 1'b1;
                     r_c_r_wb     <= 1'b1;
                     r_c_addr     <= w_d.d_box_no.no;
                     r_state      <= READ_REQ;
                  end
               end
               if (inf.box_sup_valid) begin
                  r_sup[r_sup_cnt] <= w_d.d_ing.ing;
                  r_sup_cnt        <= r_sup_cnt + 2'd1;
                  if (r_sup_cnt == 2'd3) begin
                     r_c_in_valid <= 1'b1;
                     r_c_r_wb     <= 1'b1;
                     r_c_addr     <= r_box_no;
                     r_state      <= READ_REQ;
                  end
               end
            end
            READ_REQ:  r_state <= READ_WAIT;
            READ_WAIT: begin
               if (inf.C_out_valid) begin
                  r_box   <= inf.C_data_r;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_res_err <= w_err;
               if (w_wr) begin
                  r_c_in_valid <= 1'b1;
                  r_c_r_wb     <= 1'b0;
                  r_c_data_w   <= w_new;
                  r_state      <= WRITE_REQ;
               end else begin
                  r_out_valid <= 1'b1;
                  r_err       <= w_err;
                  r_complete  <= (w_err == No_Err);
                  r_state     <= OUT;
               end
            end
            WRITE_REQ:  r_state <= WRITE_WAIT;
            WRITE_WAIT: begin
               if (inf.C_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_err       <= r_res_err;
                  r_complete  <= (r_res_err == No_Err);
                  r_state     <= OUT;
               end
            end
            OUT:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign inf.out_valid  = r_out_valid;
   assign inf.err_msg    = r_err;
   assign inf.complete   = r_complete;
   assign inf.C_addr     = r_c_addr;
   assign inf.C_r_wb     = r_c_r_wb;
   assign inf.C_in_valid = r_c_in_valid;
   assign inf.C_data_w   = r_c_data_w;

endmodule

// File: tb/tb_bev_core.sv
// Bench for bev_core: directed vector table, reset-abort sequence, and
// randomized actions against a behavioural model of the shop rules.
module tb_bev_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   INF inf();
   bev_core dut (.clk(clk), .inf(inf));

   int checks = 0;
   int errors = 0;

   // bridge model state
   logic [63:0] mem [256];
   bit          br_busy = 0;
   bit          br_hold = 0;
   int          br_cnt;
   logic [7:0]  br_a;
   logic        br_rd;
   logic [63:0] br_wd;
   int          wr_cnt = 0;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   int          mon_bad = 0;
   logic        prev_civ = 1'b0;

   typedef struct {
      logic [1:0]  act;
      logic [2:0]  typ;
      logic [1:0]  sz;
      logic [3:0]  mo;
      logic [4:0]  dy;
      logic [7:0]  no;
      logic [11:0] s0, s1, s2, s3;
      logic [63:0] init;
      logic [1:0]  e_err;
      bit          e_wr;
      logic [63:0] e_box;
   } vec_t;

   typedef struct {
      logic [1:0]  err;
      bit          wr;
      logic [63:0] box;
   } res_t;

   vec_t vt[11];

   function automatic logic [63:0] mk_box(input int bt, input int gt, input int mo,
                                          input int mk, input int pj, input int dy);
      return {bt[11:0], gt[11:0], 4'b0, mo[3:0], mk[11:0], pj[11:0], 3'b0, dy[4:0]};
   endfunction

   // Reference model: shop rules in plain integer arithmetic
   function automatic res_t model(input logic [1:0] act, input logic [2:0] typ,
                                  input logic [1:0] sz, input int mo, input int dy,
                                  input logic [63:0] b, input int s0, input int s1,
                                  input int s2, input int s3);
      res_t r;
      int v, tot;
      int p[4];
      int have[4];
      int need[4];
      int sup[4];
      int n[4];
      bit expd, shrt, of;
      have[0] = int'(b[63:52]); have[1] = int'(b[51:40]);
      have[2] = int'(b[31:20]); have[3] = int'(b[19:8]);
      expd = (mo * 32 + dy) > (int'(b[35:32]) * 32 + int'(b[4:0]));
      r.err = 2'd0; r.wr = 0; r.box = b;
      if (act == 2'd0) begin
         v = (sz == 2'd0) ? 960 : (sz == 2'd1) ? 720 : 480;
         case (typ)
            3'd0: p = '{1, 0, 0, 0};
            3'd1: p = '{3, 0, 1, 0};
            3'd2: p = '{1, 0, 1, 0};
            3'd3: p = '{0, 1, 0, 0};
            3'd4: p = '{0, 1, 1, 0};
            3'd5: p = '{0, 0, 0, 1};
            3'd6: p = '{1, 0, 0, 1};
            default: p = '{2, 0, 1, 1};
         endcase
         tot = p[0] + p[1] + p[2] + p[3];
         shrt = 0;
         for (int i = 0; i < 4; i++) begin
            need[i] = v * p[i] / tot;
            if (have[i] < need[i]) shrt = 1;
         end
         if (expd) r.err = 2'd1;
         else if (shrt) r.err = 2'd2;
         else begin
            r.wr = 1;
            r.box = {12'(have[0] - need[0]), 12'(have[1] - need[1]), b[39:32],
                     12'(have[2] - need[2]), 12'(have[3] - need[3]), b[7:0]};
         end
      end else if (act == 2'd1) begin
         sup = '{s0, s1, s2, s3};
         of = 0;
         for (int i = 0; i < 4; i++) begin
            n[i] = have[i] + sup[i];
            if (n[i] > 4095) begin n[i] = 4095; of = 1; end
         end
         r.wr = 1;
         r.err = of ? 2'd3 : 2'd0;
         r.box = {12'(n[0]), 12'(n[1]), 4'b0, 4'(mo), 12'(n[2]), 12'(n[3]), 3'b0, 5'(dy)};
      end else begin
         r.err = expd ? 2'd1 : 2'd0;
      end
      return r;
   endfunction

   task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Bridge: accept a request, answer after 1..4 cycles; reset drops it
   initial begin
      inf.C_out_valid = 1'b0;
      inf.C_data_r    = '0;
      forever begin
         @(negedge clk);
         inf.C_out_valid = 1'b0;
         if (br_busy) begin
            if (!inf.rst_n) br_busy = 0;
            else if (!br_hold) begin
               if (br_cnt == 0) begin
                  if (br_rd) inf.C_data_r = mem[br_a];
                  else begin
                     mem[br_a] = br_wd;
                     wr_cnt++;
                     wr_addr = br_a;
                     wr_data = br_wd;
                  end
                  inf.C_out_valid = 1'b1;
                  br_busy = 0;
               end else br_cnt--;
            end
         end else if (inf.rst_n && inf.C_in_valid) begin
            br_a    = inf.C_addr;
            br_rd   = inf.C_r_wb;
            br_wd   = inf.C_data_w;
            br_cnt  = $urandom_range(0, 3);
            br_busy = 1;
         end
      end
   end

   // Protocol monitor: quiet result outputs, single-cycle requests, stable request fields
   always @(negedge clk) begin
      if (inf.rst_n) begin
         if (!inf.out_valid && (inf.err_msg != 2'd0 || inf.complete)) mon_bad++;
         if (inf.out_valid && (inf.complete != (inf.err_msg == 2'd0))) mon_bad++;
         if (inf.C_in_valid && prev_civ) mon_bad++;
         if (br_busy && !inf.C_in_valid && (inf.C_addr != br_a || inf.C_r_wb != br_rd)) mon_bad++;
         prev_civ = inf.C_in_valid;
      end else prev_civ = 1'b0;
   end

   task automatic pulse(input int which, input logic [71:0] d, input bit last);
      inf.D = d;
      case (which)
         0: inf.sel_action_valid = 1'b1;
         1: inf.type_valid       = 1'b1;
         2: inf.size_valid       = 1'b1;
         3: inf.date_valid       = 1'b1;
         4: inf.box_no_valid     = 1'b1;
         default: inf.box_sup_valid = 1'b1;
      endcase
      @(negedge clk);
      inf.sel_action_valid = 1'b0; inf.type_valid = 1'b0; inf.size_valid = 1'b0;
      inf.date_valid = 1'b0; inf.box_no_valid = 1'b0; inf.box_sup_valid = 1'b0;
      inf.D = '0;
      if (!last) repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic run_txn(input vec_t v, output bit ok, output logic [1:0] err, output logic cmp);
      wr_cnt = 0;
      ok = 0; err = 2'd0; cmp = 1'b0;
      pulse(0, 72'(v.act), 0);
      if (v.act == 2'd0) begin
         pulse(1, 72'(v.typ), 0);
         pulse(2, 72'(v.sz), 0);
      end
      pulse(3, 72'({v.mo, v.dy}), 0);
      if (v.act == 2'd1) begin
         pulse(4, 72'(v.no), 0);
         pulse(5, 72'(v.s0), 0);
         pulse(5, 72'(v.s1), 0);
         pulse(5, 72'(v.s2), 0);
         pulse(5, 72'(v.s3), 1);
      end else pulse(4, 72'(v.no), 1);
      for (int i = 0; i < 1500; i++) begin
         if (inf.out_valid) begin
            ok = 1; err = inf.err_msg; cmp = inf.complete;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic verify(input string nm, input vec_t v);
      bit ok;
      logic [1:0] err;
      logic cmp;
      mem[v.no] = v.init;
      run_txn(v, ok, err, cmp);
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_out_valid required=out_valid", nm);
      end else begin
         check({nm, "_err"}, 80'(err), 80'(v.e_err));
         check({nm, "_complete"}, 80'(cmp), 80'(v.e_err == 2'd0));
         check({nm, "_wrcnt"}, 80'(wr_cnt), 80'(v.e_wr));
         if (v.e_wr && wr_cnt == 1) begin
            check({nm, "_wdata"}, 80'(wr_data), 80'(v.e_box));
            check({nm, "_waddr"}, 80'(wr_addr), 80'(v.no));
         end
      end
   endtask

   function automatic int rnd_ing();
      case ($urandom % 4)
         0: return $urandom_range(0, 500);
         1: return $urandom_range(3800, 4095);
         default: return $urandom % 4096;
      endcase
   endfunction

   initial begin
      vec_t rv;
      res_t rr;
      int bm, bd;
      #200_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      res_t rr;
      int bm, bd;
      logic [1:0] szs[3];
      szs[0] = 2'd0; szs[1] = 2'd1; szs[2] = 2'd3;

      //            act   typ   sz    mo     dy     no     s0      s1      s2     s3     init                               err   wr    new box
      vt[0]  = '{2'd0, 3'd1, 2'd0, 4'd3,  5'd10, 8'd5,  12'd0,  12'd0,  12'd0, 12'd0, mk_box(1000, 0, 3, 500, 0, 10),     2'd0, 1'b1, mk_box(280, 0, 3, 260, 0, 10)};
      vt[1]  = '{2'd0, 3'd3, 2'd3, 4'd6,  5'd1,  8'd9,  12'd0,  12'd0,  12'd0, 12'd0, mk_box(0, 1000, 5, 0, 0, 31),       2'd1, 1'b0, 64'd0};
      vt[2]  = '{2'd0, 3'd7, 2'd1, 4'd8,  5'd20, 8'd20, 12'd0,  12'd0,  12'd0, 12'd0, mk_box(2000, 0, 8, 2000, 100, 20),  2'd2, 1'b0, 64'd0};
      vt[3]  = '{2'd1, 3'd0, 2'd0, 4'd12, 5'd31, 8'd12, 12'd200, 12'd0, 12'd0, 12'd5, mk_box(4000, 10, 1, 20, 30, 1),     2'd3, 1'b1, mk_box(4095, 10, 12, 20, 35, 31)};
      vt[4]  = '{2'd2, 3'd0, 2'd0, 4'd1,  5'd1,  8'd7,  12'd0,  12'd0,  12'd0, 12'd0, mk_box(5, 5, 1, 5, 5, 1),           2'd0, 1'b0, 64'd0};
      vt[5]  = '{2'd1, 3'd0, 2'd0, 4'd2,  5'd14, 8'd30, 12'd95, 12'd4095, 12'd0, 12'd1, mk_box(4000, 0, 9, 7, 4094, 9),  2'd0, 1'b1, mk_box(4095, 4095, 2, 7, 4095, 14)};
      vt[6]  = '{2'd0, 3'd0, 2'd0, 4'd4,  5'd4,  8'd40, 12'd0,  12'd0,  12'd0, 12'd0, mk_box(960, 1, 4, 2, 3, 4),         2'd0, 1'b1, mk_box(0, 1, 4, 2, 3, 4)};
      vt[7]  = '{2'd2, 3'd0, 2'd0, 4'd3,  5'd11, 8'd41, 12'd0,  12'd0,  12'd0, 12'd0, mk_box(1, 1, 3, 1, 1, 10),          2'd1, 1'b0, 64'd0};
      vt[8]  = '{2'd0, 3'd5, 2'd3, 4'd3,  5'd31, 8'd42, 12'd0,  12'd0,  12'd0, 12'd0, mk_box(0, 0, 4, 0, 480, 1),         2'd0, 1'b1, mk_box(0, 0, 4, 0, 0, 1)};
      vt[9]  = '{2'd0, 3'd4, 2'd1, 4'd7,  5'd7,  8'd43, 12'd0,  12'd0,  12'd0, 12'd0, mk_box(0, 360, 7, 359, 0, 7),       2'd2, 1'b0, 64'd0};
      vt[10] = '{2'd0, 3'd0, 2'd0, 4'd11, 5'd2,  8'd44, 12'd0,  12'd0,  12'd0, 12'd0, mk_box(0, 0, 10, 0, 0, 30),         2'd1, 1'b0, 64'd0};

      inf.rst_n = 1'b0;
      inf.sel_action_valid = 1'b0; inf.type_valid = 1'b0; inf.size_valid = 1'b0;
      inf.date_valid = 1'b0; inf.box_no_valid = 1'b0; inf.box_sup_valid = 1'b0;
      inf.D = '0;
      repeat (3) @(negedge clk);
      check("reset_state", 80'({inf.out_valid, inf.err_msg, inf.complete, inf.C_in_valid,
                                inf.C_r_wb, inf.C_addr, inf.C_data_w}), 80'd0);
      inf.rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) verify($sformatf("vec%0d", i), vt[i]);

      // Reset while the read is outstanding
      br_hold = 1;
      mem[8'd7] = mk_box(1, 1, 1, 1, 1, 1);
      pulse(0, 72'd2, 0);
      pulse(3, 72'({4'd1, 5'd1}), 0);
      pulse(4, 72'd7, 1);
      check("rd_req", 80'({inf.C_in_valid, inf.C_r_wb, inf.C_addr}), 80'({1'b1, 1'b1, 8'd7}));
      repeat (2) @(negedge clk);
      check("rd_hold", 80'({inf.C_in_valid, inf.C_r_wb, inf.C_addr, inf.out_valid}),
            80'({1'b0, 1'b1, 8'd7, 1'b0}));
      inf.rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_op", 80'({inf.out_valid, inf.err_msg, inf.complete, inf.C_in_valid,
                               inf.C_r_wb, inf.C_addr, inf.C_data_w}), 80'd0);
      @(negedge clk);
      inf.rst_n = 1'b1;
      br_hold = 0;
      @(negedge clk);
      verify("post_rst", vt[0]);

      // Randomized actions against the model
      for (int r = 0; r < 60; r++) begin
         rv.act = 2'($urandom % 3);
         rv.typ = 3'($urandom % 8);
         rv.sz  = szs[$urandom % 3];
         rv.mo  = 4'($urandom_range(1, 12));
         rv.dy  = 5'($urandom_range(1, 31));
         rv.no  = 8'($urandom_range(100, 107));
         rv.s0  = 12'(rnd_ing()); rv.s1 = 12'(rnd_ing());
         rv.s2  = 12'(rnd_ing()); rv.s3 = 12'(rnd_ing());
         if ($urandom % 3 == 0) begin bm = rv.mo; bd = rv.dy; end
         else begin bm = $urandom_range(1, 12); bd = $urandom_range(1, 31); end
         rv.init = mk_box(rnd_ing(), rnd_ing(), bm, rnd_ing(), rnd_ing(), bd);
         rr = model(rv.act, rv.typ, rv.sz, rv.mo, rv.dy, rv.init,
                    rv.s0, rv.s1, rv.s2, rv.s3);
         rv.e_err = rr.err;
         rv.e_wr  = rr.wr;
         rv.e_box = rr.box;
         verify($sformatf("rnd%0d", r), rv);
      end

      check("protocol_monitor", 80'(mon_bad), 80'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
